controle_exibe_sequencia: RTL and testbench

- Sequencing controller that plays the stored colour sequence back on the LEDs before each player round of the memory game.
- Drives the datapath address counter and reads memory data at each address from 0 up to the current round limit.
- Lights each entry for T_ON cycles, then blanks for T_OFF cycles, and returns a one-cycle pronto.
- Sits beside the main unidade_controle. The main FSM pulses iniciar and waits for pronto before it accepts plays.

---
 rtl/controle_exibe_sequencia_pkg.sv | 19 +
 rtl/controle_exibe_sequencia_contador_tempo.sv | 33 +++
 rtl/controle_exibe_sequencia.sv | 97 +++++++++
 tb/tb_controle_exibe_sequencia.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/controle_exibe_sequencia_pkg.sv
// Shared state codes and default timing for the sequence playback controller.
// The state codes are also what the hexa7seg debug display decodes.
package controle_exibe_sequencia_pkg;

    typedef enum logic [3:0] {
        StInicial = 4'd0,
        StPrepara = 4'd1,
        StEspera  = 4'd2,
        StMostra  = 4'd3,
        StApaga   = 4'd4,
        StProximo = 4'd5,
        StFim     = 4'd6
    } estado_e;

    localparam int unsigned TOnDefault  = 50_000_000;
    localparam int unsigned TOffDefault = 25_000_000;
    localparam int unsigned TmrWDefault = 26;

endpackage

// File: rtl/controle_exibe_sequencia_contador_tempo.sv
// Cycle timer for the playback controller: synchronous clear has priority over count.
module contador_tempo_exibe #(
    parameter int unsigned TMR_W = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             zera,
    input  logic             conta,
    output logic [TMR_W-1:0] valor
);

    logic [TMR_W-1:0] valor_d, valor_q;

    always_comb begin
        valor_d = valor_q;
        if (zera) begin
            valor_d = '0;
        end else if (conta) begin
            valor_d = valor_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor = valor_q;

endmodule

// File: rtl/controle_exibe_sequencia.sv
// Plays the stored colour sequence on the LEDs (address 0 up to the round limit),
// each entry lit for T_ON cycles then dark for T_OFF cycles, ending with a pronto pulse.
module controle_exibe_sequencia
    import controle_exibe_sequencia_pkg::*;
#(
    parameter int unsigned T_ON  = TOnDefault,
    parameter int unsigned T_OFF = TOffDefault,
    parameter int unsigned TMR_W = TmrWDefault
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       endereco_igual_limite,
    input  logic [3:0] memoria,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic [3:0] leds,
    output logic       exibindo,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam logic [TMR_W-1:0] TOnFim  = TMR_W'(T_ON - 1);
    localparam logic [TMR_W-1:0] TOffFim = TMR_W'(T_OFF - 1);

    estado_e          estado_q, estado_d;
    logic [TMR_W-1:0] tempo;
    logic             tmr_zera, tmr_conta;

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado_q <= StInicial;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            StInicial: if (iniciar) estado_d = StPrepara;
            StPrepara: estado_d = StEspera;
            StEspera:  estado_d = StMostra;
            StMostra:  if (tempo == TOnFim) estado_d = StApaga;
            StApaga:   if (tempo == TOffFim) estado_d = StProximo;
            StProximo: estado_d = endereco_igual_limite ? StFim : StEspera;
            StFim:     estado_d = StInicial;
            default:   estado_d = StInicial;
        endcase
    end

    // Restart the timer on every state change so each phase counts from zero.
    assign tmr_zera  = (estado_d != estado_q);
    assign tmr_conta = (estado_q == StMostra) || (estado_q == StApaga);

    contador_tempo_exibe #(
        .TMR_W(TMR_W)
    ) u_contador_tempo (
        .clock(clock),
        .reset(reset),
        .zera (tmr_zera),
        .conta(tmr_conta),
        .valor(tempo)
    );

    always_comb begin
        zera_endereco  = 1'b0;
        conta_endereco = 1'b0;
        leds           = 4'b0000;
        exibindo       = 1'b0;
        pronto         = 1'b0;
        case (estado_q)
            StPrepara: begin
                zera_endereco = 1'b1;
                exibindo      = 1'b1;
            end
            StEspera: exibindo = 1'b1;
            StMostra: begin
                leds     = memoria;
                exibindo = 1'b1;
            end
            StApaga: exibindo = 1'b1;
            StProximo: begin
                conta_endereco = !endereco_igual_limite;
                exibindo       = 1'b1;
            end
            StFim: begin
                pronto   = 1'b1;
                exibindo = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
// Bench for controle_exibe_sequencia: datapath modelled as a 4-bit address counter plus
// a registered ROM; LED traces are compared with a trace built from the playback rules.
module tb_controle_exibe_sequencia;

    localparam int unsigned T_ON  = 4;
    localparam int unsigned T_OFF = 2;
    localparam int unsigned TMR_W = 4;
    localparam int          PER   = T_ON + T_OFF + 2;
    localparam int          BUDGET = 2 + 16 * PER + 10;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic       endereco_igual_limite;
    logic [3:0] memoria;
    logic       zera_endereco, conta_endereco, exibindo, pronto;
    logic [3:0] leds, db_estado;

    logic [3:0] addr_q = 4'd0;
    logic [3:0] mem_q  = 4'd0;
    logic [3:0] rom [16];
    logic [3:0] lim = 4'd0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] trace [$];
    int pronto_cnt, conta_cnt, zera_cnt, overlap_cnt, idle_cnt, pronto_edge;
    logic       post_pronto;
    logic [3:0] post_estado;

    controle_exibe_sequencia #(
        .T_ON (T_ON),
        .T_OFF(T_OFF),
        .TMR_W(TMR_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .iniciar              (iniciar),
        .endereco_igual_limite(endereco_igual_limite),
        .memoria              (memoria),
        .zera_endereco        (zera_endereco),
        .conta_endereco       (conta_endereco),
        .leds                 (leds),
        .exibindo             (exibindo),
        .pronto               (pronto),
        .db_estado            (db_estado)
    );

    always #5 clock = ~clock;

    // Datapath environment: memory data follows the address one cycle later.
    always @(posedge clock) begin
        if (zera_endereco) addr_q <= 4'd0;
        else if (conta_endereco) addr_q <= addr_q + 4'd1;
        mem_q <= rom[addr_q];
    end
    assign memoria = mem_q;
    assign endereco_igual_limite = (addr_q == lim);

    // Expected per-cycle LED trace from the edge that samples iniciar (cycle 1) to pronto:
    // PREPARA, then per entry ESPERA, T_ON lit, T_OFF dark, PROXIMO, then FIM.
    function automatic int first_trace_diff(input int l);
        logic [3:0] e [$];
        int n;
        e.push_back(4'd0);
        for (int i = 0; i <= l; i++) begin
            e.push_back(4'd0);
            repeat (T_ON) e.push_back(rom[i]);
            repeat (T_OFF + 1) e.push_back(4'd0);
        end
        e.push_back(4'd0);
        n = (e.size() > trace.size()) ? e.size() : trace.size();
        for (int i = 0; i < n; i++) begin
            if (i >= e.size() || i >= trace.size()) return i;
            if (e[i] !== trace[i]) return i;
        end
        return -1;
    endfunction

    function automatic int exp_latency(input int l);
        return 2 + (l + 1) * PER;
    endfunction

    // Pulse iniciar, then record outputs once per cycle until pronto (bounded).
    task automatic run_playback(input int retrig_at);
        trace.delete();
        pronto_cnt = 0; conta_cnt = 0; zera_cnt = 0; overlap_cnt = 0; idle_cnt = 0;
        pronto_edge = -1;
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        for (int k = 1; k <= BUDGET; k++) begin
            trace.push_back(leds);
            if (pronto) begin
                pronto_cnt++;
                if (pronto_edge < 0) pronto_edge = k;
            end
            if (conta_endereco) conta_cnt++;
            if (zera_endereco) zera_cnt++;
            if (zera_endereco && conta_endereco) overlap_cnt++;
            if (!exibindo) idle_cnt++;
            iniciar = (k == retrig_at);
            if (pronto_edge >= 0) break;
            @(negedge clock);
        end
        iniciar = 1'b0;
        @(negedge clock);
        post_pronto = pronto;
        post_estado = db_estado;
    endtask

    task automatic load_rom_default();
        rom[0] = 4'd3; rom[1] = 4'd1; rom[2] = 4'd2; rom[3] = 4'd0;
        for (int i = 4; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
    endtask

    task automatic test_reset();
        int seen_pronto = 0;
        reset = 1'b0; iniciar = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            if (pronto) seen_pronto++;
            tests_run++;
            if ({db_estado, leds, zera_endereco, conta_endereco, exibindo, pronto} !== 12'd0) begin
                tests_failed++;
                $display("FAIL reset_outputs[%0d]: got estado=%0d leds=%b z=%b c=%b ex=%b p=%b, expected all 0",
                         i, db_estado, leds, zera_endereco, conta_endereco, exibindo, pronto);
            end
        end
        tests_run++;
        if (seen_pronto != 0) begin
            tests_failed++;
            $display("FAIL reset_pronto: got %0d pulses, expected 0", seen_pronto);
        end
        iniciar = 1'b0; reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_single_entry();
        int d;
        lim = 4'd0; load_rom_default();
        run_playback(-1);
        d = first_trace_diff(0);
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL single_trace: first diff at cycle %0d (got %0d entries, expected none differing)", d + 1, trace.size()); end
        tests_run++; if (pronto_edge != exp_latency(0)) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", pronto_edge, exp_latency(0)); end
        tests_run++; if (conta_cnt != 0) begin tests_failed++; $display("FAIL single_conta: got %0d expected 0", conta_cnt); end
        tests_run++; if (pronto_cnt != 1 || post_pronto !== 1'b0) begin tests_failed++; $display("FAIL single_pronto_once: got %0d (+post %b) expected 1 (+post 0)", pronto_cnt, post_pronto); end
        tests_run++; if (post_estado !== 4'd0 || idle_cnt != 0) begin tests_failed++; $display("FAIL single_busy: got post estado %0d idle %0d, expected 0 and 0", post_estado, idle_cnt); end
    endtask

    task automatic test_three_entries();
        int d;
        lim = 4'd2; load_rom_default();
        run_playback(-1);
        d = first_trace_diff(2);
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL three_trace: first diff at cycle %0d, expected none", d + 1); end
        tests_run++; if (pronto_edge != exp_latency(2)) begin tests_failed++; $display("FAIL three_latency: got %0d expected %0d", pronto_edge, exp_latency(2)); end
        tests_run++; if (conta_cnt != 2 || zera_cnt != 1) begin tests_failed++; $display("FAIL three_addr_ctl: got conta %0d zera %0d expected 2 and 1", conta_cnt, zera_cnt); end
        tests_run++; if (overlap_cnt != 0) begin tests_failed++; $display("FAIL three_overlap: got %0d expected 0", overlap_cnt); end
    endtask

    task automatic test_back_to_back_retrigger();
        int d;
        lim = 4'd2; load_rom_default();
        run_playback(12);
        d = first_trace_diff(2);
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL retrig_trace: first diff at cycle %0d, expected none", d + 1); end
        tests_run++; if (pronto_edge != exp_latency(2)) begin tests_failed++; $display("FAIL retrig_latency: got %0d expected %0d", pronto_edge, exp_latency(2)); end
        tests_run++; if (pronto_cnt != 1 || post_pronto !== 1'b0 || post_estado !== 4'd0) begin tests_failed++; $display("FAIL retrig_single_pronto: got %0d post %b estado %0d expected 1, 0, 0", pronto_cnt, post_pronto, post_estado); end
    endtask

    task automatic test_abort();
        int d;
        int seen_pronto = 0;
        lim = 4'd2; load_rom_default();
        @(negedge clock); iniciar = 1'b1;
        @(negedge clock); iniciar = 1'b0;
        // Cycle 15 is the first dark cycle of entry 1.
        for (int k = 1; k < 15; k++) begin
            if (pronto) seen_pronto++;
            @(negedge clock);
        end
        tests_run++; if (db_estado !== 4'd4 || leds !== 4'd0) begin tests_failed++; $display("FAIL abort_in_apaga: got estado %0d leds %b expected 4 and 0000", db_estado, leds); end
        reset = 1'b0;
        @(negedge clock);
        if (pronto) seen_pronto++;
        tests_run++;
        if ({db_estado, leds, zera_endereco, conta_endereco, exibindo, pronto} !== 12'd0 || seen_pronto != 0) begin
            tests_failed++;
            $display("FAIL abort_reset: got estado %0d leds %b ex %b pronto seen %0d, expected all 0",
                     db_estado, leds, exibindo, seen_pronto);
        end
        reset = 1'b1;
        run_playback(-1);
        d = first_trace_diff(2);
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL abort_restart_trace: first diff at cycle %0d, expected none", d + 1); end
        tests_run++; if (pronto_edge != exp_latency(2) || zera_cnt != 1) begin tests_failed++; $display("FAIL abort_restart_latency: got %0d (zera %0d) expected %0d (zera 1)", pronto_edge, zera_cnt, exp_latency(2)); end
    endtask

    task automatic test_full_limit();
        int d;
        lim = 4'd15; load_rom_default();
        run_playback(-1);
        d = first_trace_diff(15);
        tests_run++; if (d != -1) begin tests_failed++; $display("FAIL l15_trace: first diff at cycle %0d, expected none", d + 1); end
        tests_run++; if (pronto_edge != exp_latency(15)) begin tests_failed++; $display("FAIL l15_latency: got %0d expected %0d", pronto_edge, exp_latency(15)); end
        tests_run++; if (conta_cnt != 15 || addr_q !== 4'd15) begin tests_failed++; $display("FAIL l15_addr: got conta %0d addr %0d expected 15 and 15", conta_cnt, addr_q); end
    endtask

    task automatic test_random();
        int d;
        int l;
        for (int it = 0; it < 4; it++) begin
            l = $urandom_range(0, 15);
            lim = 4'(l);
            for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 15));
            run_playback((it == 1) ? 3 + $urandom_range(0, 10) : -1);
            d = first_trace_diff(l);
            tests_run++; if (d != -1) begin tests_failed++; $display("FAIL random_trace[L=%0d]: first diff at cycle %0d, expected none", l, d + 1); end
            tests_run++; if (pronto_edge != exp_latency(l) || conta_cnt != l) begin tests_failed++; $display("FAIL random_timing[L=%0d]: got edge %0d conta %0d expected %0d and %0d", l, pronto_edge, conta_cnt, exp_latency(l), l); end
        end
    endtask

    task automatic test_continuous_start();
        int edges [$];
        int consec = 0;
        int done = 0;
        logic prev = 1'b0;
        lim = 4'd0; load_rom_default();
        @(negedge clock); iniciar = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (pronto) edges.push_back(k);
            if (pronto && prev) consec++;
            prev = pronto;
        end
        iniciar = 1'b0;
        tests_run++; if (edges.size() != 3 || consec != 0) begin tests_failed++; $display("FAIL cont_pulses: got %0d pulses (%0d wide) expected 3 single-cycle", edges.size(), consec); end
        for (int i = 1; i < edges.size(); i++) begin
            tests_run++;
            if (edges[i] - edges[i-1] != PER + 3) begin tests_failed++; $display("FAIL cont_period[%0d]: got %0d expected %0d", i, edges[i] - edges[i-1], PER + 3); end
        end
        for (int k = 0; k < 3 * PER && done == 0; k++) begin
            @(negedge clock);
            if (db_estado == 4'd0 && !exibindo) done = 1;
        end
        tests_run++; if (done != 1) begin tests_failed++; $display("FAIL cont_return_idle: got estado %0d expected 0 within bound", db_estado); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
        test_reset();
        test_single_entry();
        test_three_entries();
        test_back_to_back_retrigger();
        test_abort();
        test_full_limit();
        test_random();
        test_continuous_start();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
